// File: rtl/raizing_video_pkg.sv
// Shared Raizing video-path definitions: text-ROM requester indices and the
// round-robin selection helper used by the text-ROM arbiter.
package raizing_video_pkg;

    localparam int unsigned TXTARB_TEXT  = 0;
    localparam int unsigned TXTARB_EXTRA = 1;
    localparam int unsigned TXTARB_DBG   = 2;

    localparam int unsigned RR_MAX = 4;
    localparam int unsigned RR_IW  = 2;

    typedef struct packed {
        logic             found;
        logic [RR_IW-1:0] idx;
    } rr_pick_t;

    // First eligible index at or above ptr, wrapping at n_req.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] eligible,
                                         input logic [RR_IW-1:0]  ptr,
                                         input int unsigned       n_req);
        rr_pick_t    r;
        int unsigned cand;
        r = '0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            cand = (32'(ptr) + k) % n_req;
            if (k < n_req && !r.found && eligible[RR_IW'(cand)]) begin
                r.found = 1'b1;
                r.idx   = RR_IW'(cand);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/raizing_textrom_arb_if.sv
// Requester and ROM-side signals of the shared text-ROM arbiter.
interface raizing_textrom_arb_if #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned AW    = 14,
    parameter int unsigned DW    = 16
);
    logic [N_REQ-1:0]    REQ;
    logic [N_REQ*AW-1:0] ADDR;
    logic                PRIO0;
    logic [N_REQ-1:0]    ACK;
    logic [DW-1:0]       DOUT;
    logic [N_REQ-1:0]    DVALID;
    logic [AW-1:0]       ROM_ADDR;
    logic                ROM_CS;
    logic [DW-1:0]       ROM_DATA;

    modport master (output REQ, ADDR, PRIO0, ROM_DATA,
                    input  ACK, DOUT, DVALID, ROM_ADDR, ROM_CS);

    modport slave  (input  REQ, ADDR, PRIO0, ROM_DATA,
                    output ACK, DOUT, DVALID, ROM_ADDR, ROM_CS);
endinterface

// File: rtl/raizing_tag_pipe.sv
// Shift register of {valid, id} tags that follows each issued ROM read until
// its data is due; synchronous clear drops everything in flight.
module raizing_tag_pipe #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned IDW   = 2
) (
    input  logic           clk_i,
    input  logic           clr_i,
    input  logic           vld_i,
    input  logic [IDW-1:0] id_i,
    output logic           vld_o,
    output logic [IDW-1:0] id_o
);
    logic [DEPTH-1:0]          vld_q;
    logic [DEPTH-1:0][IDW-1:0] id_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            vld_q[0] <= vld_i;
            id_q[0]  <= id_i;
            for (int unsigned s = 1; s < DEPTH; s++) begin
                vld_q[s] <= vld_q[s-1];
                id_q[s]  <= id_q[s-1];
            end
        end
    end

    assign vld_o = vld_q[DEPTH-1];
    assign id_o  = id_q[DEPTH-1];
endmodule

// File: rtl/raizing_textrom_arb.sv
// Round-robin (optional requester-0 priority) arbiter sharing one synchronous
// text-ROM port; returns each word to its requester LAT cycles after ACK.
module raizing_textrom_arb
    import raizing_video_pkg::*;
#(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned AW    = 14,
    parameter int unsigned DW    = 16,
    parameter int unsigned LAT   = 2
) (
    input  logic                   CLK96,
    input  logic                   RESET96,
    raizing_textrom_arb_if.slave   bus
);
    localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] ack_q, ack_d;
    logic [N_REQ-1:0] dvalid_q, dvalid_d;
    logic [DW-1:0]    dout_q;
    logic [AW-1:0]    rom_addr_q, rom_addr_d;
    logic             rom_cs_q;
    logic [IDW-1:0]   ptr_q, ptr_d;

    logic [N_REQ-1:0] eligible;
    rr_pick_t         pick;
    logic             grant;
    logic [IDW-1:0]   gnt_id;
    logic             ret_vld;
    logic [IDW-1:0]   ret_id;

    // ack_q doubles as the mask: a requester cannot win again before it sees its ACK.
    always_comb begin
        eligible   = bus.REQ & ~ack_q;
        pick       = rr_pick(RR_MAX'(eligible), RR_IW'(ptr_q), N_REQ);
        grant      = pick.found;
        gnt_id     = IDW'(pick.idx);
        if (bus.PRIO0 && eligible[0]) begin
            grant  = 1'b1;
            gnt_id = '0;
        end
        ack_d      = '0;
        ptr_d      = ptr_q;
        rom_addr_d = rom_addr_q;
        if (grant) begin
            ack_d[gnt_id] = 1'b1;
            ptr_d         = (32'(gnt_id) + 32'd1 == N_REQ) ? '0 : IDW'(32'(gnt_id) + 32'd1);
            rom_addr_d    = bus.ADDR[32'(gnt_id)*AW +: AW];
        end
        dvalid_d = '0;
        if (ret_vld) dvalid_d[ret_id] = 1'b1;
    end

    // Registered DVALID/DOUT form the last stage of the return path.
    raizing_tag_pipe #(.DEPTH(LAT), .IDW(IDW)) u_tag_pipe (
        .clk_i (CLK96),
        .clr_i (RESET96),
        .vld_i (grant),
        .id_i  (gnt_id),
        .vld_o (ret_vld),
        .id_o  (ret_id)
    );

    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            ack_q      <= '0;
            dvalid_q   <= '0;
            dout_q     <= '0;
            rom_addr_q <= '0;
            rom_cs_q   <= 1'b0;
            ptr_q      <= '0;
        end else begin
            ack_q      <= ack_d;
            dvalid_q   <= dvalid_d;
            rom_addr_q <= rom_addr_d;
            rom_cs_q   <= grant;
            ptr_q      <= ptr_d;
            if (ret_vld) dout_q <= bus.ROM_DATA;
        end
    end

    assign bus.ACK      = ack_q;
    assign bus.DVALID   = dvalid_q;
    assign bus.DOUT     = dout_q;
    assign bus.ROM_ADDR = rom_addr_q;
    assign bus.ROM_CS   = rom_cs_q;
endmodule

// File: tb/tb_raizing_textrom_arb.sv
// Directed bench for the text-ROM arbiter: a LAT=2 instance and a LAT=4 instance,
// each fed by a behavioural ROM returning addr ^ 16'hA5C3.
module tb_raizing_textrom_arb;
    import raizing_video_pkg::*;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 14;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    raizing_textrom_arb_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus_a ();
    raizing_textrom_arb_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus_b ();

    raizing_textrom_arb #(.N_REQ(N), .AW(AW), .DW(DW), .LAT(2)) u_dut_a (
        .CLK96   (clk),
        .RESET96 (rst_a),
        .bus     (bus_a)
    );

    raizing_textrom_arb #(.N_REQ(N), .AW(AW), .DW(DW), .LAT(4)) u_dut_b (
        .CLK96   (clk),
        .RESET96 (rst_b),
        .bus     (bus_b)
    );

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return {2'b00, a} ^ 16'hA5C3;
    endfunction

    // ROM models: data for the address registered at edge E is sampled at E+LAT.
    logic [DW-1:0] rom_a_q;
    logic [DW-1:0] rom_b_q [3];
    always @(posedge clk) begin
        rom_a_q    <= rom_word(bus_a.ROM_ADDR);
        rom_b_q[0] <= rom_word(bus_b.ROM_ADDR);
        rom_b_q[1] <= rom_b_q[0];
        rom_b_q[2] <= rom_b_q[1];
    end
    assign bus_a.ROM_DATA = rom_a_q;
    assign bus_b.ROM_DATA = rom_b_q[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_a(input string tag, input logic [2:0] ack, input logic [2:0] dv);
        check_eq({tag, " ack"},    32'(bus_a.ACK),    32'(ack));
        check_eq({tag, " cs"},     32'(bus_a.ROM_CS), 32'(ack != 3'b000));
        check_eq({tag, " dvalid"}, 32'(bus_a.DVALID), 32'(dv));
    endtask

    task automatic set_addr_a(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        bus_a.ADDR = {a2, a1, a0};
    endtask

    task automatic pulse_reset_a();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
    endtask

    logic [2:0]    gseq [6];
    logic [DW-1:0] wseq [6];

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.REQ = '0; bus_a.PRIO0 = 1'b0; bus_a.ADDR = '0;
        bus_b.REQ = '0; bus_b.PRIO0 = 1'b0; bus_b.ADDR = '0;
        tick();
        tick();

        // Reset values
        expect_a("reset", 3'b000, 3'b000);
        check_eq("reset dout",  32'(bus_a.DOUT),     32'h0);
        check_eq("reset raddr", 32'(bus_a.ROM_ADDR), 32'h0);

        // Single requester 1
        rst_a = 1'b0;
        bus_a.REQ = 3'b010;
        set_addr_a(14'h0, 14'h0123, 14'h0);
        tick();
        expect_a("single e1", 3'b010, 3'b000);
        check_eq("single e1 raddr", 32'(bus_a.ROM_ADDR), 32'h0123);
        bus_a.REQ = 3'b000;
        tick();
        expect_a("single e2", 3'b000, 3'b000);
        tick();
        expect_a("single e3", 3'b000, 3'b010);
        check_eq("single e3 dout", 32'(bus_a.DOUT), 32'hA4E0);
        tick();
        expect_a("single e4", 3'b000, 3'b000);

        // All three requesting, pure round-robin from pointer 0
        pulse_reset_a();
        bus_a.REQ = 3'b111;
        set_addr_a(14'h0100, 14'h0200, 14'h0300);
        gseq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        wseq = '{16'hA4C3, 16'hA7C3, 16'hA6C3, 16'hA4C3, 16'hA7C3, 16'hA6C3};
        for (int e = 1; e <= 8; e++) begin
            tick();
            expect_a($sformatf("rr e%0d", e), (e <= 6) ? gseq[e-1] : 3'b000,
                     (e >= 3) ? gseq[e-3] : 3'b000);
            if (e >= 3) check_eq($sformatf("rr e%0d dout", e), 32'(bus_a.DOUT), 32'(wseq[e-3]));
            if (e == 6) bus_a.REQ = 3'b000;
        end

        // PRIO0: requester 0 every other cycle, mask-limited
        pulse_reset_a();
        bus_a.PRIO0 = 1'b1;
        bus_a.REQ = 3'b111;
        gseq = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010};
        for (int e = 1; e <= 8; e++) begin
            tick();
            expect_a($sformatf("prio e%0d", e), (e <= 6) ? gseq[e-1] : 3'b000,
                     (e >= 3) ? gseq[e-3] : 3'b000);
            if (e == 6) begin
                bus_a.REQ = 3'b000;
                bus_a.PRIO0 = 1'b0;
            end
        end

        // Reset while two reads are in flight
        pulse_reset_a();
        bus_a.REQ = 3'b111;
        tick();
        expect_a("midrst e1", 3'b001, 3'b000);
        tick();
        expect_a("midrst e2", 3'b010, 3'b000);
        rst_a = 1'b1;
        tick();
        expect_a("midrst e3", 3'b000, 3'b000);
        check_eq("midrst e3 dout",  32'(bus_a.DOUT),     32'h0);
        check_eq("midrst e3 raddr", 32'(bus_a.ROM_ADDR), 32'h0);
        rst_a = 1'b0;
        tick();
        expect_a("midrst e4", 3'b001, 3'b000);
        tick();
        expect_a("midrst e5", 3'b010, 3'b000);
        bus_a.REQ = 3'b000;
        tick();
        expect_a("midrst e6", 3'b000, 3'b001);
        check_eq("midrst e6 dout", 32'(bus_a.DOUT), 32'hA4C3);
        tick();
        expect_a("midrst e7", 3'b000, 3'b010);

        // REQ[2] pulsed for one cycle while requester 0 wins
        pulse_reset_a();
        bus_a.REQ = 3'b101;
        set_addr_a(14'h0011, 14'h0000, 14'h3FFF);
        tick();
        expect_a("pulse e1", 3'b001, 3'b000);
        check_eq("pulse e1 raddr", 32'(bus_a.ROM_ADDR), 32'h0011);
        bus_a.REQ = 3'b000;
        tick();
        expect_a("pulse e2", 3'b000, 3'b000);
        check_eq("pulse e2 raddr", 32'(bus_a.ROM_ADDR), 32'h0011);
        tick();
        expect_a("pulse e3", 3'b000, 3'b001);
        check_eq("pulse e3 dout", 32'(bus_a.DOUT), 32'hA5D2);
        tick();
        expect_a("pulse e4", 3'b000, 3'b000);

        // LAT=4 instance: back-to-back grants to 1 then 2
        rst_b = 1'b0;
        bus_b.REQ = 3'b110;
        bus_b.ADDR = {14'h1555, 14'h0AAA, 14'h0000};
        tick();
        check_eq("lat4 e1 ack",   32'(bus_b.ACK),      32'(3'b010));
        check_eq("lat4 e1 raddr", 32'(bus_b.ROM_ADDR), 32'h0AAA);
        bus_b.REQ = 3'b100;
        tick();
        check_eq("lat4 e2 ack",   32'(bus_b.ACK),      32'(3'b100));
        check_eq("lat4 e2 raddr", 32'(bus_b.ROM_ADDR), 32'h1555);
        bus_b.REQ = 3'b000;
        for (int e = 3; e <= 7; e++) begin
            tick();
            check_eq($sformatf("lat4 e%0d ack", e), 32'(bus_b.ACK), 32'h0);
            check_eq($sformatf("lat4 e%0d dvalid", e), 32'(bus_b.DVALID),
                     (e == 5) ? 32'h2 : (e == 6) ? 32'h4 : 32'h0);
            if (e == 5) check_eq("lat4 e5 dout", 32'(bus_b.DOUT), 32'hAF69);
            if (e == 6) check_eq("lat4 e6 dout", 32'(bus_b.DOUT), 32'hB096);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
